// File: rtl/multi_cycle_control.sv
// multi_cycle_control
//   Multi-cycle control unit for the MIPS-subset CPU. An FSM steps each
//   instruction through IF/ID/EXE/MEM/WB and drives the datapath selects and
//   write enables from {state, halted, op, zero}. It also counts retired
//   instructions, meaning the number of PCWre pulses.
//
// Ports
//   CLK        in   system clock, rising edge
//   Reset      in   asynchronous active-high reset
//   op[5:0]    in   IR opcode, valid from ID onward
//   zero       in   ALU zero flag, used in EXE_BR only
//   PCWre      out  PC write enable
//   PcSrc[1:0] out  00 PC+4, 01 branch target, 10 jump target
//   InsMemRw   out  instruction memory read
//   IRWre      out  IR load enable
//   ExtSel     out  1 sign-extend, 0 zero-extend
//   ALUSrcA    out  1 shamt, 0 rs
//   ALUSrcB    out  1 immediate, 0 rt
//   ALUOp[2:0] out  ALU function
//   RegDst     out  1 rd, 0 rt
//   RegWre     out  register file write enable
//   mRD, mWR   out  data memory read / write
//   DBDataSrc  out  1 memory data, 0 ALU result on the writeback bus
//   state[2:0] out  current state encoding (debug)
//   retired    out  retired instruction count, wraps at 16 bits
//
// state  | meaning
// -------+-----------------------------------------------
// IF     | fetch, load IR (also reported while halted)
// ID     | decode; j and undefined opcodes retire here
// EXE_LS | address calculation for lw/sw
// MEM    | data memory access; sw retires here
// WB_LD  | load writeback
// EXE_BR | branch compare and retire
// EXE_AL | ALU operation
// WB_AL  | ALU writeback and retire
module multi_cycle_control (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  op,
  input  logic        zero,
  output logic        PCWre,
  output logic [1:0]  PcSrc,
  output logic        InsMemRw,
  output logic        IRWre,
  output logic        ExtSel,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        RegDst,
  output logic        RegWre,
  output logic        mRD,
  output logic        mWR,
  output logic        DBDataSrc,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_SUBI = 6'b000011;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b011001;
  localparam logic [5:0] OP_SLTI = 6'b011011;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t      state_q;
  logic        halted_q;
  logic [15:0] retired_q;

  logic is_alu, is_ls, is_br, is_j, is_halt;

  // ALU-group select decode, held through EXE_AL and WB_AL
  logic       alu_ext, alu_srca, alu_srcb, alu_regdst;
  logic [2:0] alu_op;

  always_comb begin
    is_alu     = 1'b0;
    alu_ext    = 1'b0;
    alu_srca   = 1'b0;
    alu_srcb   = 1'b0;
    alu_regdst = 1'b0;
    alu_op     = 3'b000;
    case (op)
      OP_ADD:  begin is_alu = 1'b1; alu_regdst = 1'b1; alu_op = 3'b000; end
      OP_ADDI: begin is_alu = 1'b1; alu_srcb = 1'b1; alu_ext = 1'b1; alu_op = 3'b000; end
      OP_SUB:  begin is_alu = 1'b1; alu_regdst = 1'b1; alu_op = 3'b001; end
      OP_SUBI: begin is_alu = 1'b1; alu_srcb = 1'b1; alu_ext = 1'b1; alu_op = 3'b001; end
      OP_ORI:  begin is_alu = 1'b1; alu_srcb = 1'b1; alu_op = 3'b011; end
      OP_AND:  begin is_alu = 1'b1; alu_regdst = 1'b1; alu_op = 3'b100; end
      OP_OR:   begin is_alu = 1'b1; alu_regdst = 1'b1; alu_op = 3'b011; end
      OP_SLL:  begin is_alu = 1'b1; alu_srca = 1'b1; alu_regdst = 1'b1; alu_op = 3'b010; end
      OP_SLT:  begin is_alu = 1'b1; alu_regdst = 1'b1; alu_op = 3'b101; end
      OP_SLTI: begin is_alu = 1'b1; alu_srcb = 1'b1; alu_ext = 1'b1; alu_op = 3'b101; end
      default: ;
    endcase
  end

  assign is_ls   = (op == OP_LW) || (op == OP_SW);
  assign is_br   = (op == OP_BEQ) || (op == OP_BNE);
  assign is_j    = (op == OP_J);
  assign is_halt = (op == OP_HALT);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IF;
      halted_q  <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      if (PCWre) retired_q <= retired_q + 16'h0001;
      if (!halted_q) begin
        case (state_q)
          S_IF: state_q <= S_ID;
          S_ID: begin
            if (is_halt) begin
              // halt parks the FSM in the IF slot with the sticky flag set
              halted_q <= 1'b1;
              state_q  <= S_IF;
            end else if (is_br)  state_q <= S_EXE_BR;
            else if (is_alu)     state_q <= S_EXE_AL;
            else if (is_ls)      state_q <= S_EXE_LS;
            else                 state_q <= S_IF;
          end
          S_EXE_LS: state_q <= S_MEM;
          S_MEM:    state_q <= (op == OP_LW) ? S_WB_LD : S_IF;
          S_WB_LD:  state_q <= S_IF;
          S_EXE_BR: state_q <= S_IF;
          S_EXE_AL: state_q <= S_WB_AL;
          S_WB_AL:  state_q <= S_IF;
          default:  state_q <= S_IF;
        endcase
      end
    end
  end

  always_comb begin
    PCWre     = 1'b0;
    PcSrc     = 2'b00;
    InsMemRw  = 1'b0;
    IRWre     = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    RegDst    = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    if (!halted_q) begin
      case (state_q)
        S_IF: begin
          InsMemRw = 1'b1;
          IRWre    = 1'b1;
        end
        S_ID: begin
          InsMemRw = 1'b1;
          if (is_j) begin
            PCWre = 1'b1;
            PcSrc = 2'b10;
          end else if (!(is_alu || is_ls || is_br || is_halt)) begin
            PCWre = 1'b1;  // undefined opcode retires as a NOP
          end
        end
        S_EXE_AL, S_WB_AL: begin
          ExtSel  = alu_ext;
          ALUSrcA = alu_srca;
          ALUSrcB = alu_srcb;
          ALUOp   = alu_op;
          RegDst  = alu_regdst;
          if (state_q == S_WB_AL) begin
            RegWre = 1'b1;
            PCWre  = 1'b1;
          end
        end
        S_EXE_BR: begin
          ExtSel = 1'b1;
          ALUOp  = 3'b001;
          PCWre  = 1'b1;
          if (((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero)) PcSrc = 2'b01;
        end
        S_EXE_LS, S_MEM, S_WB_LD: begin
          ALUSrcB = 1'b1;
          ExtSel  = 1'b1;
          if (state_q == S_MEM) begin
            if (op == OP_SW) begin
              mWR   = 1'b1;
              PCWre = 1'b1;
            end else begin
              mRD = 1'b1;
            end
          end else if (state_q == S_WB_LD) begin
            mRD       = 1'b1;
            DBDataSrc = 1'b1;
            RegWre    = 1'b1;
            PCWre     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule
